// File: rtl/snake_gfx_pkg.sv
// Shared constants for the snake game graphics path: requester count, ROM geometry
// and the fixed requester ids used by the sprite fetch units.
package snake_gfx_pkg;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 12;
    localparam int ROM_LAT_DEF = 2;

    typedef enum logic [1:0] {
        REQ_HEAD  = 2'd0,
        REQ_BODY  = 2'd1,
        REQ_APPLE = 2'd2,
        REQ_WALL  = 2'd3
    } req_id_e;

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority one-hot grant: the search starts at pointer p and wraps,
// so the first requester at or after p wins.
module rr_grant #(
    parameter int NUM_REQ = snake_gfx_pkg::NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   p,
    output logic [NUM_REQ-1:0] gnt
);
    import snake_gfx_pkg::*;

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(p) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shared sprite ROM arbiter: round-robin grant, registered ROM request and a
// latency-matched tag pipeline that routes each returned pixel to its requester.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = snake_gfx_pkg::NUM_REQ,
    parameter int ADDR_W  = snake_gfx_pkg::ADDR_W,
    parameter int DATA_W  = snake_gfx_pkg::DATA_W,
    parameter int ROM_LAT = snake_gfx_pkg::ROM_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sof,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [15:0]               conflict_cnt
);
    import snake_gfx_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               romEn_q, romEn_d;
    logic [ADDR_W-1:0]  romAddr_q, romAddr_d;
    logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];
    logic [NUM_REQ-1:0] rspValid_q, rspValid_d;
    logic [DATA_W-1:0]  rspData_q, rspData_d;
    logic [15:0]        conflictCnt_q, conflictCnt_d;

    logic [NUM_REQ-1:0] gntRaw;
    logic [NUM_REQ-1:0] gntLive;
    logic [ADDR_W-1:0]  gntAddr;
    logic [PTR_W-1:0]   gntIdx;
    logic               anyGnt;
    logic               contended;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uGrant (
        .req (req),
        .p   (ptr_q),
        .gnt (gntRaw)
    );

    // Grant is masked while reset is held so no requester sees a stale win.
    assign gntLive   = rst ? gntRaw : '0;
    assign anyGnt    = |gntLive;
    assign contended = (req & (req - NUM_REQ'(1))) != '0;

    always_comb begin
        gntAddr = '0;
        gntIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gntLive[k]) begin
                gntAddr = req_addr[k*ADDR_W +: ADDR_W];
                gntIdx  = PTR_W'(k);
            end
        end
    end

    // sof only affects the next arbitration; this cycle still used the old pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (sof) begin
            ptr_d = '0;
        end else if (anyGnt) begin
            ptr_d = (gntIdx == PTR_W'(NUM_REQ - 1)) ? '0 : gntIdx + PTR_W'(1);
        end

        romEn_d   = anyGnt;
        romAddr_d = anyGnt ? gntAddr : romAddr_q;

        conflictCnt_d = conflictCnt_q;
        if (sof) begin
            conflictCnt_d = '0;
        end else if (contended && (conflictCnt_q != 16'hFFFF)) begin
            conflictCnt_d = conflictCnt_q + 16'd1;
        end

        rspValid_d = tag_q[ROM_LAT];
        rspData_d  = (|tag_q[ROM_LAT]) ? rom_data : rspData_q;
    end

    // Tag entry 0 lines up with rom_addr; entry ROM_LAT lines up with rom_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q         <= '0;
            romEn_q       <= 1'b0;
            romAddr_q     <= '0;
            rspValid_q    <= '0;
            rspData_q     <= '0;
            conflictCnt_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            romEn_q       <= romEn_d;
            romAddr_q     <= romAddr_d;
            rspValid_q    <= rspValid_d;
            rspData_q     <= rspData_d;
            conflictCnt_q <= conflictCnt_d;
            tag_q[0]      <= gntLive;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign gnt          = gntLive;
    assign rom_en       = romEn_q;
    assign rom_addr     = romAddr_q;
    assign rsp_valid    = rspValid_q;
    assign rsp_data     = rspData_q;
    assign conflict_cnt = conflictCnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(gntLive));
            assert ((gntLive & ~req) == '0);
            assert ($onehot0(rspValid_q));
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: a queue-based reference of grants,
// ROM reads and tagged responses, plus hand-computed literal scenarios.
module tb_sprite_rom_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 16;
    localparam int DW      = 12;
    localparam int ROM_LAT = 2;
    localparam int LAT     = 2 + ROM_LAT;

    logic              clk = 1'b0;
    logic              rst;
    logic              sof;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ-1:0]   gnt;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [15:0]       conflict_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        int          k;
        logic [15:0] addr;
    } rsp_t;

    rsp_t        rspQ[$];
    int          mPtr;
    int          mConf;
    int          cycle = 0;
    logic        mEn;
    logic [15:0] mAddr;
    int          mGrants;
    int          mRsps;
    logic [15:0] romPipe [ROM_LAT];

    sprite_rom_arbiter #(
        .NUM_REQ (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sof          (sof),
        .req          (req),
        .req_addr     (reqAddr),
        .gnt          (gnt),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] romWord(input logic [15:0] a);
        return a[11:0] ^ {3{a[15:12]}} ^ 12'hA5C;
    endfunction

    // Synchronous ROM with ROM_LAT clocks from address to data.
    always @(posedge clk) begin
        romPipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            romPipe[i] <= romPipe[i-1];
        end
    end
    assign rom_data = romWord(romPipe[ROM_LAT-1]);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [NREQ-1:0] r,
                                 input logic [NREQ*AW-1:0] a);
        @(posedge clk);
        #1;
        sof     = s;
        req     = r;
        reqAddr = a;
    endtask

    function automatic void clearModel();
        mPtr    = 0;
        mConf   = 0;
        mEn     = 1'b0;
        mAddr   = '0;
        mGrants = 0;
        mRsps   = 0;
        rspQ.delete();
    endfunction

    always @(negedge rst) clearModel();

    // Reference model: inputs are stable from posedge+1, so the negedge sees the
    // values the coming posedge will act on.
    always @(negedge clk) begin
        logic [NREQ-1:0] expGnt;
        int              gk;
        int              k;
        logic [15:0]     ga;
        cycle++;
        if (!rst) begin
            clearModel();
            checkOutput("rstGnt", gnt, 0);
            checkOutput("rstRomEn", rom_en, 0);
            checkOutput("rstRomAddr", rom_addr, 0);
            checkOutput("rstRspValid", rsp_valid, 0);
            checkOutput("rstRspData", rsp_data, 0);
            checkOutput("rstConflict", conflict_cnt, 0);
        end else begin
            expGnt = '0;
            gk     = -1;
            for (int i = 0; i < NREQ; i++) begin
                k = (mPtr + i) % NREQ;
                if (gk < 0 && req[k]) gk = k;
            end
            if (gk >= 0) expGnt[gk] = 1'b1;

            checkOutput("gnt", gnt, expGnt);
            checkOutput("romEn", rom_en, mEn);
            if (mEn) checkOutput("romAddr", rom_addr, mAddr);
            if (rspQ.size() > 0 && rspQ[0].due == cycle) begin
                checkOutput("rspValid", rsp_valid, 1 << rspQ[0].k);
                checkOutput("rspData", rsp_data, romWord(rspQ[0].addr));
                void'(rspQ.pop_front());
            end else begin
                checkOutput("rspIdle", rsp_valid, 0);
            end
            checkOutput("conflict", conflict_cnt, mConf);
            if (rsp_valid != 0) mRsps++;

            mEn = (gk >= 0);
            if (gk >= 0) begin
                ga    = reqAddr[gk*AW +: AW];
                mAddr = ga;
                rspQ.push_back('{cycle + LAT, gk, ga});
                mGrants++;
                mPtr = (gk + 1) % NREQ;
            end
            if (sof) mPtr = 0;
            if (sof) mConf = 0;
            else if ($countones(req) >= 2 && mConf < 65535) mConf++;
        end
    end

    initial begin
        logic [NREQ*AW-1:0] fixedAddr;
        logic [NREQ*AW-1:0] pendAddr;
        logic [NREQ-1:0]    pendReq;
        logic [NREQ-1:0]    lastGnt;
        int                 hits;

        rst     = 1'b0;
        sof     = 1'b0;
        req     = 4'b1011;
        reqAddr = 64'h1234_5678_9ABC_DEF0;
        #2;
        checkOutput("holdRstGnt", gnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;

        // Single read of 0x0040 through the whole pipeline.
        fixedAddr = {16'h0300, 16'h0200, 16'h0100, 16'h0040};
        applyStimulus(1'b0, 4'b0001, fixedAddr);
        #1 checkOutput("singleGnt", gnt, 4'b0001);
        applyStimulus(1'b0, 4'b0000, fixedAddr);
        #1 checkOutput("singleRomEn", rom_en, 1);
        checkOutput("singleRomAddr", rom_addr, 16'h0040);
        repeat (2) applyStimulus(1'b0, 4'b0000, fixedAddr);
        applyStimulus(1'b0, 4'b0000, fixedAddr);
        #1 checkOutput("singleRspValid", rsp_valid, 4'b0001);
        checkOutput("singleRspData", rsp_data, 12'hA1C);

        // All four contending for eight cycles from p=0.
        fixedAddr = {16'h7000, 16'h6010, 16'h5020, 16'h4030};
        applyStimulus(1'b1, 4'b0000, fixedAddr);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'b1111, fixedAddr);
            #1 checkOutput("rrGnt", gnt, 4'b0001 << (i % 4));
            if (i >= 4) checkOutput("rrRsp", rsp_valid, 4'b0001 << (i - 4));
        end
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 4'b0000, fixedAddr);
            #1;
            if (j == 0) checkOutput("rrConflict", conflict_cnt, 8);
            checkOutput("rrRspTail", rsp_valid, 4'b0001 << j);
        end

        // Two contenders, then sof with a lone wall request.
        applyStimulus(1'b1, 4'b0000, fixedAddr);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0101, fixedAddr);
            #1 checkOutput("altGnt", gnt, (i % 2 == 0) ? 4'b0001 : 4'b0100);
        end
        applyStimulus(1'b1, 4'b1000, fixedAddr);
        #1 checkOutput("sofGnt", gnt, 4'b1000);
        checkOutput("sofConflictBefore", conflict_cnt, 4);
        applyStimulus(1'b0, 4'b1111, fixedAddr);
        #1 checkOutput("sofConflictAfter", conflict_cnt, 0);
        checkOutput("sofPtrZero", gnt, 4'b0001);
        applyStimulus(1'b0, 4'b0000, fixedAddr);

        // Saturation of the conflict counter, then sof overriding an increment.
        applyStimulus(1'b1, 4'b0000, fixedAddr);
        repeat (65540) applyStimulus(1'b0, 4'b1111, fixedAddr);
        applyStimulus(1'b1, 4'b1111, fixedAddr);
        #1 checkOutput("satConflict", conflict_cnt, 16'hFFFF);
        applyStimulus(1'b0, 4'b0000, fixedAddr);
        #1 checkOutput("satSofClear", conflict_cnt, 0);

        // Asynchronous reset mid-cycle with three reads in flight.
        fixedAddr = {16'h0F00, 16'h0ABC, 16'h0123, 16'h0456};
        repeat (3) applyStimulus(1'b0, 4'b0111, fixedAddr);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 checkOutput("midRstGnt", gnt, 0);
        checkOutput("midRstRomEn", rom_en, 0);
        checkOutput("midRstRomAddr", rom_addr, 0);
        checkOutput("midRstRspValid", rsp_valid, 0);
        checkOutput("midRstRspData", rsp_data, 0);
        checkOutput("midRstConflict", conflict_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sof = 1'b0;
        req = '0;
        hits = 0;
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 4'b0000, fixedAddr);
            #1;
            if (rsp_valid != 0) hits++;
        end
        checkOutput("noStaleRsp", hits, 0);

        // Random requesters that hold req and address until granted.
        pendReq  = '0;
        pendAddr = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            #1 lastGnt = gnt;
            pendReq &= ~lastGnt;
            for (int k = 0; k < NREQ; k++) begin
                if (!pendReq[k] && $urandom_range(0, 2) == 0) begin
                    pendReq[k]             = 1'b1;
                    pendAddr[k*AW +: AW]   = 16'($urandom);
                end
            end
            applyStimulus(($urandom_range(0, 63) == 0), pendReq, pendAddr);
        end
        repeat (8) applyStimulus(1'b0, 4'b0000, pendAddr);
        #1 checkOutput("grantRspBalance", mRsps, mGrants);
        checkOutput("queueDrained", rspQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
